// File: rtl/mux_scan_sequencer_if.sv
// Control-side bundle of the mux scan sequencer: launch request, scan
// settings and the busy/done/sample read-back.
interface mux_scan_sequencer_if #(
    parameter int DWELL_W = 8
);
    logic               start;
    logic [DWELL_W-1:0] dwell;
    logic [3:0]         en_mask;
    logic               busy;
    logic               done;
    logic [3:0]         sample;
    logic [3:0]         sample_valid;

    modport master (
        output start,
        output dwell,
        output en_mask,
        input  busy,
        input  done,
        input  sample,
        input  sample_valid
    );

    modport slave (
        input  start,
        input  dwell,
        input  en_mask,
        output busy,
        output done,
        output sample,
        output sample_valid
    );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Steps the 4:1 mux select through the enabled channels, dwells on each,
// and captures the fed-back mux output into a per-channel snapshot.
module mux_scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux_scan_sequencer_if.slave  ctl,
    input  logic                 mux_x,
    output logic                 sel_a,
    output logic                 sel_b
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             nxt_state;
    logic [1:0]         ch;
    logic [1:0]         nxt_ch;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] nxt_cnt;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] nxt_dwell;
    logic [3:0]         mask_q;
    logic [3:0]         nxt_mask;
    logic [3:0]         smp;
    logic [3:0]         nxt_smp;
    logic [3:0]         vld;
    logic [3:0]         nxt_vld;
    logic               busy_q;
    logic               nxt_busy;
    logic               done_q;
    logic               nxt_done;
    logic [3:0]         above;
    logic               last_hold;

    function automatic logic [1:0] lowest(input logic [3:0] m);
        logic [1:0] idx;
        idx = 2'd3;
        priority case (1'b1)
            m[0]:    idx = 2'd0;
            m[1]:    idx = 2'd1;
            m[2]:    idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    // Enabled channels strictly above the current one; empty means last.
    assign above     = mask_q & (4'b1110 << ch);
    assign last_hold = (cnt == dwell_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = state;
        unique case (state)
            IDLE: begin
                if (ctl.start) begin
                    nxt_state = (ctl.en_mask != 4'b0) ? DWELL : DONE;
                end
            end
            DWELL: begin
                if (last_hold && above == 4'b0) begin
                    nxt_state = DONE;
                end
            end
            DONE:    nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        nxt_ch    = ch;
        nxt_cnt   = cnt;
        nxt_dwell = dwell_q;
        nxt_mask  = mask_q;
        nxt_smp   = smp;
        nxt_vld   = vld;
        nxt_busy  = busy_q;
        nxt_done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (ctl.start) begin
                    nxt_smp = 4'b0;
                    nxt_vld = 4'b0;
                    nxt_cnt = '0;
                    if (ctl.en_mask != 4'b0) begin
                        nxt_dwell = ctl.dwell;
                        nxt_mask  = ctl.en_mask;
                        nxt_ch    = lowest(ctl.en_mask);
                        nxt_busy  = 1'b1;
                    end else begin
                        nxt_done = 1'b1;
                    end
                end
            end
            DWELL: begin
                if (last_hold) begin
                    nxt_cnt     = '0;
                    nxt_smp[ch] = mux_x;
                    nxt_vld[ch] = 1'b1;
                    if (above != 4'b0) begin
                        nxt_ch = lowest(above);
                    end else begin
                        nxt_ch   = 2'd0;
                        nxt_busy = 1'b0;
                        nxt_done = 1'b1;
                    end
                end else begin
                    nxt_cnt = cnt + DWELL_W'(1);
                end
            end
            DONE: begin
                nxt_ch   = 2'd0;
                nxt_busy = 1'b0;
            end
            default: begin
                nxt_ch   = 2'd0;
                nxt_busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch      <= 2'd0;
            cnt     <= '0;
            dwell_q <= '0;
            mask_q  <= 4'b0;
            smp     <= 4'b0;
            vld     <= 4'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ch      <= nxt_ch;
            cnt     <= nxt_cnt;
            dwell_q <= nxt_dwell;
            mask_q  <= nxt_mask;
            smp     <= nxt_smp;
            vld     <= nxt_vld;
            busy_q  <= nxt_busy;
            done_q  <= nxt_done;
        end
    end

    assign sel_a            = ch[0];
    assign sel_b            = ch[1];
    assign ctl.busy         = busy_q;
    assign ctl.done         = done_q;
    assign ctl.sample       = smp;
    assign ctl.sample_valid = vld;

endmodule
